// File: rtl/wb_pkg.sv
// Shared types and constants for the write-back stage and its register file.
package wb_pkg;

  localparam int          XLEN_C      = 32;
  localparam int          REG_IDX_W   = 5;
  localparam logic [31:0] BUBBLE_INST = 32'h0;
  localparam logic [31:0] PC_STEP     = 32'd4;

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_MEM  = 2'b01,
    WB_PC4  = 2'b10,
    WB_RSVD = 2'b11
  } wb_sel_e;

endpackage

// File: rtl/regfile_array.sv
// Integer register file: x0 hardwired to zero, two asynchronous read ports.
// Optional same-cycle write-through is enabled by defining WB_BYPASS_EN.
module regfile_array
  import wb_pkg::*;
#(
  parameter int XLEN  = XLEN_C,
  parameter int NREGS = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we_i,
  input  logic [REG_IDX_W-1:0] waddr_i,
  input  logic [XLEN-1:0]      wdata_i,
  input  logic [REG_IDX_W-1:0] raddr1_i,
  input  logic [REG_IDX_W-1:0] raddr2_i,
  output logic [XLEN-1:0]      rdata1_o,
  output logic [XLEN-1:0]      rdata2_o
);

  logic [XLEN-1:0] mem_q [NREGS];

  // Index 0 is never written, so its storage stays at the reset value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i && (waddr_i != '0)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_comb begin
    rdata1_o = mem_q[raddr1_i];
    rdata2_o = mem_q[raddr2_i];
`ifdef WB_BYPASS_EN
    if (we_i && (waddr_i == raddr1_i)) rdata1_o = wdata_i;
    if (we_i && (waddr_i == raddr2_i)) rdata2_o = wdata_i;
`endif
    if (raddr1_i == '0) rdata1_o = '0;
    if (raddr2_i == '0) rdata2_o = '0;
  end

endmodule

// File: rtl/wb_regfile_unit.sv
// Write-back stage: selects the write-back value, owns the register file and
// counts retired instructions. Optional macro WB_BYPASS_EN (see regfile_array).
module wb_regfile_unit
  import wb_pkg::*;
#(
  parameter int XLEN  = XLEN_C,
  parameter int NREGS = 32,
  parameter int CNT_W = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           sel_wb_W,
  input  logic                 rf_en_W,
  input  logic [REG_IDX_W-1:0] rd_W,
  input  logic [XLEN-1:0]      inst_W,
  input  logic [XLEN-1:0]      pc_W,
  input  logic [XLEN-1:0]      alu_out_W,
  input  logic [XLEN-1:0]      out_data_W,
  input  logic [REG_IDX_W-1:0] rs1_addr,
  input  logic [REG_IDX_W-1:0] rs2_addr,
  output logic [XLEN-1:0]      rs1_data,
  output logic [XLEN-1:0]      rs2_data,
  output logic [XLEN-1:0]      wb_data_W,
  output logic                 wb_wr_W,
  output logic [CNT_W-1:0]     instret
);

  logic [CNT_W-1:0] instret_q;
  logic [CNT_W-1:0] instret_d;

  always_comb begin
    case (wb_sel_e'(sel_wb_W))
      WB_ALU:  wb_data_W = alu_out_W;
      WB_MEM:  wb_data_W = out_data_W;
      WB_PC4:  wb_data_W = pc_W + XLEN'(PC_STEP);
      default: wb_data_W = '0;
    endcase
  end

  assign wb_wr_W = rf_en_W && (rd_W != '0);

  regfile_array #(
    .XLEN  (XLEN),
    .NREGS (NREGS)
  ) u_regfile_array (
    .clk      (clk),
    .rst      (rst),
    .we_i     (wb_wr_W),
    .waddr_i  (rd_W),
    .wdata_i  (wb_data_W),
    .raddr1_i (rs1_addr),
    .raddr2_i (rs2_addr),
    .rdata1_o (rs1_data),
    .rdata2_o (rs2_data)
  );

  // Every non-bubble instruction retires here, whether or not it writes a register.
  always_comb begin
    instret_d = instret_q;
    if (inst_W != XLEN'(BUBBLE_INST)) instret_d = instret_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) instret_q <= '0;
    else     instret_q <= instret_d;
  end

  assign instret = instret_q;

endmodule

// File: tb/tb_wb_regfile_unit.sv
// Directed self-checking bench for wb_regfile_unit; expectations follow
// WB_BYPASS_EN when that macro is defined for the build.
module tb_wb_regfile_unit;

  logic        clk;
  logic        rst;
  logic [1:0]  sel_wb_W;
  logic        rf_en_W;
  logic [4:0]  rd_W;
  logic [31:0] inst_W;
  logic [31:0] pc_W;
  logic [31:0] alu_out_W;
  logic [31:0] out_data_W;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [31:0] wb_data_W;
  logic        wb_wr_W;
  logic [63:0] instret;

  int errorCount = 0;
  int checkCount = 0;

  wb_regfile_unit dut (
    .clk        (clk),
    .rst        (rst),
    .sel_wb_W   (sel_wb_W),
    .rf_en_W    (rf_en_W),
    .rd_W       (rd_W),
    .inst_W     (inst_W),
    .pc_W       (pc_W),
    .alu_out_W  (alu_out_W),
    .out_data_W (out_data_W),
    .rs1_addr   (rs1_addr),
    .rs2_addr   (rs2_addr),
    .rs1_data   (rs1_data),
    .rs2_data   (rs2_data),
    .wb_data_W  (wb_data_W),
    .wb_wr_W    (wb_wr_W),
    .instret    (instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] sel, input logic en, input logic [4:0] rd,
                               input logic [31:0] inst, input logic [31:0] pc,
                               input logic [31:0] alu, input logic [31:0] memData);
    sel_wb_W   = sel;
    rf_en_W    = en;
    rd_W       = rd;
    inst_W     = inst;
    pc_W       = pc;
    alu_out_W  = alu;
    out_data_W = memData;
  endtask

  task automatic idle();
    applyStimulus(2'b00, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
  endtask

  // Inputs change 1ns after the rising edge, so outputs are sampled mid-cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic writeAlu(input logic [4:0] rd, input logic [31:0] value);
    applyStimulus(2'b00, 1'b1, rd, 32'h13, 32'h0, value, 32'h0);
    tick();
    idle();
    #1;
  endtask

  logic [31:0] sameCycleExp;

  initial begin
    rst = 1'b1;
    rs1_addr = 5'd0;
    rs2_addr = 5'd0;
    idle();
    #2;
    rs1_addr = 5'd5;
    checkOutput("reset_x5", {32'h0, rs1_data}, 64'h0);
    checkOutput("reset_instret", instret, 64'h0);
    tick();
    tick();
    rst = 1'b0;

    writeAlu(5'd5, 32'h1234);
    rs1_addr = 5'd5;
    #1;
    checkOutput("first_write_x5", {32'h0, rs1_data}, 64'h1234);

    // Mid-run reset clears everything with no clock edge; the pending write is lost.
    applyStimulus(2'b00, 1'b1, 5'd6, 32'h13, 32'h0, 32'h6666, 32'h0);
    rst = 1'b1;
    #1;
    checkOutput("async_reset_x5", {32'h0, rs1_data}, 64'h0);
    checkOutput("async_reset_instret", instret, 64'h0);
    tick();
    rs1_addr = 5'd6;
    #1;
    checkOutput("reset_drops_write_x6", {32'h0, rs1_data}, 64'h0);
    idle();
    @(negedge clk);
    rst = 1'b0;
    tick();

    applyStimulus(2'b00, 1'b1, 5'd3, 32'h33, 32'h0, 32'hDEADBEEF, 32'h0);
    #1;
    checkOutput("wbdata_alu", {32'h0, wb_data_W}, 64'hDEADBEEF);
    checkOutput("wbwr_alu", {63'h0, wb_wr_W}, 64'h1);
    tick(); idle(); rs1_addr = 5'd3; #1;
    checkOutput("read_x3_alu", {32'h0, rs1_data}, 64'hDEADBEEF);

    applyStimulus(2'b01, 1'b1, 5'd3, 32'h3, 32'h0, 32'h0, 32'h55);
    #1;
    checkOutput("wbdata_mem", {32'h0, wb_data_W}, 64'h55);
    tick(); idle(); #1;
    checkOutput("read_x3_mem", {32'h0, rs1_data}, 64'h55);

    applyStimulus(2'b10, 1'b1, 5'd3, 32'h6F, 32'h100, 32'h0, 32'h0);
    #1;
    checkOutput("wbdata_pc4", {32'h0, wb_data_W}, 64'h104);
    tick(); idle(); #1;
    checkOutput("read_x3_pc4", {32'h0, rs1_data}, 64'h104);

    applyStimulus(2'b10, 1'b1, 5'd3, 32'h6F, 32'hFFFFFFFC, 32'h0, 32'h0);
    #1;
    checkOutput("wbdata_pc4_wrap", {32'h0, wb_data_W}, 64'h0);
    tick(); idle(); #1;
    checkOutput("read_x3_pc4_wrap", {32'h0, rs1_data}, 64'h0);

    applyStimulus(2'b11, 1'b1, 5'd6, 32'h13, 32'h200, 32'hAAAA, 32'hBBBB);
    #1;
    checkOutput("wbdata_reserved", {32'h0, wb_data_W}, 64'h0);
    idle();

    applyStimulus(2'b00, 1'b1, 5'd0, 32'h13, 32'h0, 32'hFFFFFFFF, 32'h0);
    rs1_addr = 5'd0;
    #1;
    checkOutput("wbwr_x0", {63'h0, wb_wr_W}, 64'h0);
    tick(); idle(); #1;
    checkOutput("read_x0", {32'h0, rs1_data}, 64'h0);

    writeAlu(5'd7, 32'h77);
    applyStimulus(2'b00, 1'b0, 5'd7, 32'h23, 32'h0, 32'h99, 32'h0);
    rs1_addr = 5'd7;
    #1;
    checkOutput("wbwr_en0", {63'h0, wb_wr_W}, 64'h0);
    tick(); idle(); #1;
    checkOutput("x7_unchanged", {32'h0, rs1_data}, 64'h77);

    writeAlu(5'd9, 32'h11);
`ifdef WB_BYPASS_EN
    sameCycleExp = 32'h22;
`else
    sameCycleExp = 32'h11;
`endif
    applyStimulus(2'b00, 1'b1, 5'd9, 32'h13, 32'h0, 32'h22, 32'h0);
    rs1_addr = 5'd9;
    rs2_addr = 5'd9;
    #1;
    checkOutput("same_cycle_rs1", {32'h0, rs1_data}, {32'h0, sameCycleExp});
    checkOutput("same_cycle_rs2", {32'h0, rs2_data}, {32'h0, sameCycleExp});
    tick(); idle(); #1;
    checkOutput("after_write_rs1", {32'h0, rs1_data}, 64'h22);
    checkOutput("after_write_rs2", {32'h0, rs2_data}, 64'h22);

    rs1_addr = 5'd4;
    rs2_addr = 5'd0;
    applyStimulus(2'b00, 1'b1, 5'd4, 32'h13, 32'h0, 32'h1, 32'h0);
    tick();
    applyStimulus(2'b00, 1'b1, 5'd4, 32'h13, 32'h0, 32'h2, 32'h0);
    #1;
`ifdef WB_BYPASS_EN
    checkOutput("b2b_intermediate", {32'h0, rs1_data}, 64'h2);
`else
    checkOutput("b2b_intermediate", {32'h0, rs1_data}, 64'h1);
`endif
    tick(); idle(); #1;
    checkOutput("b2b_final", {32'h0, rs1_data}, 64'h2);

    // Fresh reset so the retire count starts from a known zero.
    rst = 1'b1;
    #1;
    checkOutput("instret_cleared", instret, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      idle();
      tick();
    end
    checkOutput("instret_bubbles", instret, 64'h0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(2'b00, (i != 2), 5'd10, 32'h100 + i, 32'h0, i, 32'h0);
      tick();
    end
    idle();
    #1;
    checkOutput("instret_five", instret, 64'h5);

    force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    checkOutput("instret_forced", instret, 64'hFFFF_FFFF_FFFF_FFFF);
    release dut.instret_q;
    applyStimulus(2'b00, 1'b0, 5'd0, 32'h63, 32'h0, 32'h0, 32'h0);
    tick();
    idle();
    #1;
    checkOutput("instret_wrap", instret, 64'h0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
